// File: rtl/mmm_adj_loader.sv
`default_nettype none
// ============================================================================
// Module      : mmm_adj_loader
// Description : Streams one graph problem (header word + dense adjacency
//               bitmap) into an adjacency RAM. Rows are written at a fixed
//               stride of MAX_V/DATA_W words. Bits beyond n_vertices and
//               (optionally) self-loop bits are cleared on the way in.
//               Problems larger than MAX_V are consumed without writes and
//               flagged with o_err, so the stream stays aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module mmm_adj_loader #(
  parameter int DATA_W   = 32,
  parameter int MAX_V    = 1024,
  parameter int CLR_DIAG = 1,
  localparam int STRIDE  = MAX_V / DATA_W,
  localparam int AW      = $clog2(MAX_V * STRIDE)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_indata,
  input  logic              i_indata_ready,
  output logic              o_indata_want,
  output logic              o_hdr_valid,
  output logic [15:0]       o_init_maxsize,
  output logic [15:0]       o_n_vertices,
  output logic              o_wr_en,
  output logic [AW-1:0]     o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_done,
  output logic              o_err,
  input  logic              i_ack
);

  localparam int LW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_want;
  logic                r_hdr_valid;
  logic [15:0]         r_init;
  logic [15:0]         r_n;
  logic [15:0]         r_nc;
  logic [15:0]         r_row;
  logic [15:0]         r_col;
  logic                r_wr_en;
  logic [AW-1:0]       r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_done;
  logic                r_err;

  logic                w_xfer;
  logic [15:0]         w_hdr_n;
  logic [16:0]         w_hdr_sum;
  logic [15:0]         w_hdr_nc;
  logic                w_hdr_zero;
  logic                w_hdr_big;
  logic                w_last;
  logic                w_col_wrap;
  logic [31:0]         w_base;
  logic [AW-1:0]       w_addr;
  logic [DATA_W-1:0]   w_mask;

  // A word moves only when both sides agree on the same edge
  assign w_xfer     = i_indata_ready & r_want;

  // Header decode; NC is the number of words per adjacency row
  assign w_hdr_n    = i_indata[31:16];
  assign w_hdr_sum  = {1'b0, w_hdr_n} + 17'(DATA_W - 1);
  assign w_hdr_nc   = 16'(w_hdr_sum >> LW);
  assign w_hdr_zero = (w_hdr_n == 16'd0);
  assign w_hdr_big  = (32'(w_hdr_n) > 32'(MAX_V));

  // Row/column position within the current problem
  assign w_col_wrap = (r_col == r_nc - 16'd1);
  assign w_last     = w_col_wrap && (r_row == r_n - 16'd1);

  // RAM address: rows sit at a fixed stride regardless of n_vertices
  assign w_addr     = AW'(r_row) * AW'(STRIDE) + AW'(r_col);

  // First vertex index covered by the current column word
  assign w_base     = 32'(r_col) << LW;

  // Keep only bits for real vertices, optionally dropping the self-loop
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < DATA_W; b++) begin
      w_mask[b] = ((w_base + 32'(b)) < 32'(r_n)) &&
                  !((CLR_DIAG != 0) && ((w_base + 32'(b)) == 32'(r_row)));
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_xfer) begin
          if (w_hdr_zero) begin
            w_state_nxt = S_DONE;
          end else if (w_hdr_big) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD, S_DRAIN: begin
        if (w_xfer && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ack) begin
          w_state_nxt = S_HDR;
        end
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  // Datapath: header capture, counters, write port and completion flags
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_want      <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_init      <= 16'd0;
      r_n         <= 16'd0;
      r_nc        <= 16'd0;
      r_row       <= 16'd0;
      r_col       <= 16'd0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Registered so it tracks the state the FSM is entering
      r_want      <= (w_state_nxt != S_DONE);
      r_hdr_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (w_xfer) begin
            r_init      <= i_indata[15:0];
            r_n         <= w_hdr_n;
            r_nc        <= w_hdr_nc;
            r_row       <= 16'd0;
            r_col       <= 16'd0;
            r_hdr_valid <= 1'b1;
            if (w_hdr_zero) begin
              r_done <= 1'b1;
            end
          end
        end
        S_LOAD, S_DRAIN: begin
          if (w_xfer) begin
            if (r_state == S_LOAD) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_addr;
              r_wr_data <= i_indata & w_mask;
            end
            if (w_col_wrap) begin
              r_col <= 16'd0;
              r_row <= r_row + 16'd1;
            end else begin
              r_col <= r_col + 16'd1;
            end
            if (w_last) begin
              r_done <= 1'b1;
              r_err  <= (r_state == S_DRAIN);
            end
          end
        end
        S_DONE: begin
          if (i_ack) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_indata_want  = r_want;
  assign o_hdr_valid    = r_hdr_valid;
  assign o_init_maxsize = r_init;
  assign o_n_vertices   = r_n;
  assign o_wr_en        = r_wr_en;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_data      = r_wr_data;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mmm_adj_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmm_adj_loader
// Description : Scoreboard bench for mmm_adj_loader (DATA_W=32, MAX_V=64,
//               CLR_DIAG=1). The sequencer pushes expected writes, header
//               pulses and completions with their due times; a monitor pops
//               and compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmm_adj_loader;

  localparam int DW = 32;
  localparam int MV = 64;
  localparam int AWT = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   indata;
  logic            ready;
  logic            want;
  logic            hdr_valid;
  logic [15:0]     init_ms;
  logic [15:0]     nv;
  logic            wr_en;
  logic [AWT-1:0]  wr_addr;
  logic [DW-1:0]   wr_data;
  logic            done;
  logic            err;
  logic            ack;

  mmm_adj_loader #(.DATA_W(DW), .MAX_V(MV), .CLR_DIAG(1)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_indata       (indata),
    .i_indata_ready (ready),
    .o_indata_want  (want),
    .o_hdr_valid    (hdr_valid),
    .o_init_maxsize (init_ms),
    .o_n_vertices   (nv),
    .o_wr_en        (wr_en),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .o_done         (done),
    .o_err          (err),
    .i_ack          (ack)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct { logic [AWT-1:0] addr; logic [31:0] data; time t; } wr_t;
  typedef struct { logic [15:0] init; logic [15:0] n; time t; } hdr_t;
  typedef struct { logic e; time t; } done_t;

  wr_t   wq[$];
  hdr_t  hq[$];
  done_t dq[$];
  logic  prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic spurious(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Reference mask: keep vertices below n, drop the diagonal
  function automatic logic [31:0] mdl(input int r, input int c, input int n, input logic [31:0] w);
    logic [31:0] m;
    m = w;
    for (int b = 0; b < 32; b++) begin
      if ((c * 32 + b) >= n || (c * 32 + b) == r) m[b] = 1'b0;
    end
    return m;
  endfunction

  // Monitor: compare every presented output against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (wq.size() == 0) spurious("wr_spurious", {25'd0, wr_addr, wr_data});
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e.addr));
          chk("wr_data", 64'(wr_data), 64'(e.data));
          chk("wr_time", 64'($time), 64'(e.t));
        end
      end
      if (hdr_valid) begin
        if (hq.size() == 0) spurious("hdr_spurious", {32'd0, nv, init_ms});
        else begin
          hdr_t h;
          h = hq.pop_front();
          chk("hdr_fields", {32'd0, nv, init_ms}, {32'd0, h.n, h.init});
          chk("hdr_time", 64'($time), 64'(h.t));
        end
      end
      if (done && !prev_done) begin
        if (dq.size() == 0) spurious("done_spurious", 64'(err));
        else begin
          done_t d;
          d = dq.pop_front();
          chk("done_err", 64'(err), 64'(d.e));
          chk("done_time", 64'($time), 64'(d.t));
        end
      end
    end
    prev_done = done;
  end

  // Present a word at a negedge and hold it until the loader wants it;
  // returns the negedge time preceding the accepting edge
  task automatic send(input logic [31:0] w, output time t);
    int n;
    n = 0;
    indata = w;
    ready  = 1'b1;
    while (!want && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!want) spurious("accept_timeout", 64'(w));
    t = $time;
  endtask

  task automatic exp_wr(input int addr, input logic [31:0] d, input time t);
    wq.push_back('{AWT'(addr), d, t + 10});
  endtask

  // Wait for completion, check the DONE level behaviour, then release
  task automatic finish_problem();
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 64'(done), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("want_in_done", 64'(want), 64'd0);
      @(negedge clk);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("done_cleared", {62'd0, done, err}, 64'd0);
    chk("want_after_ack", 64'(want), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    time t;
    logic [31:0] d;
    rst_n  = 1'b0;
    ready  = 1'b0;
    indata = '0;
    ack    = 1'b0;
    #1;
    chk("rst_ctrl", {59'd0, want, hdr_valid, wr_en, done, err}, 64'd0);
    chk("rst_hdr", {32'd0, nv, init_ms}, 64'd0);
    chk("rst_wr", {25'd0, wr_addr, wr_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("want_after_rst", 64'(want), 64'd1);

    // n=3, all ones: diagonal and out-of-range bits cleared
    send(32'h0003_0002, t); hq.push_back('{16'd2, 16'd3, t + 10}); @(negedge clk);
    send(32'hFFFF_FFFF, t); exp_wr(0, 32'h6, t); @(negedge clk);
    send(32'hFFFF_FFFF, t); exp_wr(2, 32'h5, t); @(negedge clk);
    send(32'hFFFF_FFFF, t); exp_wr(4, 32'h3, t); dq.push_back('{1'b0, t + 10}); @(negedge clk);
    ready = 1'b0;
    finish_problem();

    // n=5, mixed patterns; ack held mid-load must be ignored
    send(32'h0005_BEEF, t); hq.push_back('{16'hBEEF, 16'd5, t + 10}); @(negedge clk);
    ack = 1'b1;
    send(32'hFFFF_FFF5, t); exp_wr(0, 32'h14, t); @(negedge clk);
    send(32'hFFFF_FFFF, t); exp_wr(2, 32'h1D, t); @(negedge clk);
    send(32'h0000_0004, t); exp_wr(4, 32'h0,  t); @(negedge clk);
    ack = 1'b0;
    send(32'h0000_000A, t); exp_wr(6, 32'h2,  t); @(negedge clk);
    send(32'h8000_0010, t); exp_wr(8, 32'h0,  t); dq.push_back('{1'b0, t + 10}); @(negedge clk);
    ready = 1'b0;
    finish_problem();

    // n=40: two words per row, 80 writes
    send(32'h0028_0011, t); hq.push_back('{16'h11, 16'd40, t + 10}); @(negedge clk);
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 2; c++) begin
        send(32'hFFFF_FFFF, t);
        if (r == 0 && c == 1)       d = 32'h0000_00FF;
        else if (r == 39 && c == 1) d = 32'h0000_007F;
        else                        d = mdl(r, c, 40, 32'hFFFF_FFFF);
        exp_wr(r * 2 + c, d, t);
        if (r == 39 && c == 1) dq.push_back('{1'b0, t + 10});
        @(negedge clk);
      end
    end
    ready = 1'b0;
    finish_problem();

    // n=65 exceeds MAX_V: 195 words drained, no writes, error flagged
    send(32'h0041_0000, t); hq.push_back('{16'h0, 16'd65, t + 10}); @(negedge clk);
    for (int i = 0; i < 195; i++) begin
      send(32'hA5A5_0000 + 32'(i), t);
      if (i == 194) dq.push_back('{1'b1, t + 10});
      @(negedge clk);
    end
    ready = 1'b0;
    finish_problem();

    // Following problem decodes correctly: n=4, init=7
    send(32'h0004_0007, t); hq.push_back('{16'd7, 16'd4, t + 10}); @(negedge clk);
    send(32'h0000_000F, t); exp_wr(0, 32'hE, t); @(negedge clk);
    send(32'h0000_000F, t); exp_wr(2, 32'hD, t); @(negedge clk);
    send(32'h0000_000F, t); exp_wr(4, 32'hB, t); @(negedge clk);
    send(32'h0000_000F, t); exp_wr(6, 32'h7, t); dq.push_back('{1'b0, t + 10}); @(negedge clk);
    ready = 1'b0;
    finish_problem();

    // n=0: done one cycle after the header, no writes
    send(32'h0000_0009, t); hq.push_back('{16'd9, 16'd0, t + 10}); dq.push_back('{1'b0, t + 10});
    @(negedge clk);
    ready = 1'b0;
    finish_problem();

    // Gaps on every other cycle during a 3-vertex load
    send(32'h0003_0055, t); hq.push_back('{16'h55, 16'd3, t + 10}); @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      ready = 1'b0;
      @(negedge clk);
      send(32'hFFFF_FFFF, t);
      exp_wr(r * 2, mdl(r, 0, 3, 32'hFFFF_FFFF), t);
      if (r == 2) dq.push_back('{1'b0, t + 10});
      @(negedge clk);
    end
    ready = 1'b0;
    finish_problem();

    // Reset after the 5th LOAD word abandons the problem
    send(32'h0028_0003, t); hq.push_back('{16'd3, 16'd40, t + 10}); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      send(32'h1234_5678 ^ 32'(k), t);
      exp_wr((k / 2) * 2 + (k % 2), mdl(k / 2, k % 2, 40, 32'h1234_5678 ^ 32'(k)), t);
      @(negedge clk);
    end
    ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {59'd0, want, hdr_valid, wr_en, done, err}, 64'd0);
    chk("arst_hdr", {32'd0, nv, init_ms}, 64'd0);
    chk("arst_wr", {25'd0, wr_addr, wr_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("want_after_arst", 64'(want), 64'd1);
    send(32'h0002_0001, t); hq.push_back('{16'd1, 16'd2, t + 10}); @(negedge clk);
    send(32'hFFFF_FFFF, t); exp_wr(0, 32'h2, t); @(negedge clk);
    send(32'hFFFF_FFFF, t); exp_wr(2, 32'h1, t); dq.push_back('{1'b0, t + 10}); @(negedge clk);
    ready = 1'b0;
    finish_problem();

    repeat (5) @(negedge clk);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("hq_drained", 64'(hq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
